spi_frame_rx: RTL
=================

Name: spi_frame_rx

Overview:
SPI target (slave) that receives the 40-bit flattened note/command frame from the MCU. It delivers that frame as a parallel word plus a one-cycle valid strobe to the enables stage, which consumes it. It also returns a status byte to the MCU on sdo during the same transaction, so the MCU can poll whether music is playing. All SPI pins are oversampled in the single clk domain; there is no second clock.

Parameters:
FRAME_W, 40, payload bits per frame (MSB first)
SYNC_STAGES, 2, flip-flop synchronizer depth on sck, sdi, ce (minimum 2)
STAT_W, 8, width of the status word shifted out on sdo

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
sck  input  1  SPI clock from MCU, mode 0 (idle low)
sdi  input  1  SPI data from MCU
ce  input  1  chip enable from MCU, active-high; high for the whole transaction
sdo  output  1  SPI data to MCU
status_in  input  STAT_W  status to report; bit STAT_W-1 = makingMusic
frame  output  FRAME_W  last good frame (flattenedMCUout source)
frame_valid  output  1  one-clk pulse: frame just updated
frame_err  output  1  one-clk pulse: transaction ended with wrong bit count or bad parity
busy  output  1  high while a transaction is in progress (synchronized ce)

Behaviour:
- Reset is async, active-high. While reset is asserted: frame=0, frame_valid=0, frame_err=0, sdo=0, busy=0, bit count=0, state=IDLE, synchronizers cleared.
- sck, sdi and ce each pass through SYNC_STAGES flops. sck and ce edges are detected from the last two synchronized samples.
- Supported sck frequency: at most clk/8.
- State machine IDLE -> SHIFT -> DONE -> IDLE.
  - IDLE: on ce rise, clear bit count, load tx shift register with status_in, set sdo=status_in[STAT_W-1], then enter SHIFT.
  - SHIFT, sck rise: shift sdi into the rx shift register LSB, so the first bit received ends at the MSB. Increment the count, saturating at FRAME_W+2.
  - SHIFT, sck fall: shift the tx register left and drive the next bit on sdo. After STAT_W bits, sdo=0.
  - SHIFT, ce fall: enter DONE.
  - DONE, lasts one clk: if count==EXPECTED (FRAME_W, or FRAME_W+1 with parity), frame <= rx payload and frame_valid=1. Otherwise frame keeps its value and frame_err=1. Then return to IDLE.
- Latency: frame_valid is high in clk cycle SYNC_STAGES+2 after the ce pin falls, measured from the first clk edge sampling ce low.
- busy = synchronized ce.
- sck edges while in IDLE are ignored.
- Extra bits: a frame with more than EXPECTED bits sets frame_err. The count saturates, so very long frames cannot wrap into a false match.
- A ce fall with zero sck edges produces frame_err, not frame_valid.
- A ce rise in the same clk cycle as DONE is accepted on the next clk cycle in IDLE; the edge is held by the synchronizer history and is not lost.
- status_in is sampled only at ce rise. Changes during a transaction do not affect sdo.
- Reset mid-transaction: all state clears. The next transaction starts only at the next ce rise after reset deasserts; a ce already high at deassertion is ignored until it falls and rises again.

Optional Feature:
SPI_PARITY_EN
- Defined: the MCU sends one even-parity bit after the FRAME_W payload bits, so EXPECTED=FRAME_W+1. In DONE the payload is the first FRAME_W bits received. If the XOR of payload and parity bit is not 0, frame_err=1 and frame is unchanged.
- Undefined: EXPECTED=FRAME_W with no parity check; parity logic is absent.

Test Plan:
- Reset with ce=0 -> frame=0, frame_valid=0, frame_err=0, sdo=0, busy=0.
- ce=1, 40 sck pulses sending 40'h00_0000_0003, ce=0 -> one frame_valid pulse SYNC_STAGES+2 clks after the ce fall; frame=40'h3.
- status_in=8'h80 at ce rise, 40-bit frame 40'hC -> sdo bits over the first 8 sck falls read 1,0,0,0,0,0,0,0; frame=40'hC.
- ce=1, 39 sck pulses, ce=0 -> frame_err pulse, no frame_valid, frame holds the previous 40'hC. Repeat with 45 pulses -> same result.
- Reset asserted after 20 bits of a frame, released with ce still high, then ce=0 -> no frame_valid and no frame_err. Next full frame 40'hF -> frame=40'hF.
- SPI_PARITY_EN defined: 40'hF with parity 0 -> valid, frame=40'hF. 40'hF with parity 1 -> frame_err, frame unchanged.

Source files
------------

// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - SPI mode-0 target receiving a FRAME_W-bit frame and returning a status byte on sdo
// Optional even-parity bit after the payload: define SPI_PARITY_EN.
module spi_frame_rx #(
    parameter int FRAME_W     = 40,
    parameter int SYNC_STAGES = 2,
    parameter int STAT_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sck,
    input  logic               sdi,
    input  logic               ce,
    output logic               sdo,
    input  logic [STAT_W-1:0]  status_in,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_valid,
    output logic               frame_err,
    output logic               busy
);

`ifdef SPI_PARITY_EN
    localparam int EXPECTED = FRAME_W + 1;
`else
    localparam int EXPECTED = FRAME_W;
`endif
    localparam int CNT_MAX = FRAME_W + 2;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXPECTED);
    localparam logic [CNT_W-1:0] SAT_CNT = CNT_W'(CNT_MAX);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, ce_sync;
    logic                   sck_prev, ce_prev;
    logic [SYNC_STAGES:0]   fill;
    logic                   armed;
    logic [CNT_W-1:0]       count;
    logic [EXPECTED-1:0]    rx;
    logic [STAT_W-1:0]      tx;

    logic sck_s, sdi_s, ce_s;
    logic sck_rise, sck_fall, ce_fall, start;
    logic parity_ok;
    logic [FRAME_W-1:0] payload;

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign sdi_s = sdi_sync[SYNC_STAGES-1];
    assign ce_s  = ce_sync[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign ce_fall  = ce_prev & ~ce_s;
    // armed remembers a genuine low on ce, so a rise landing in DONE is still taken
    // and a ce already high when reset releases never starts a transaction.
    assign start    = armed & ce_s;
    assign busy     = ce_s;
    assign payload  = rx[EXPECTED-1 -: FRAME_W];

`ifdef SPI_PARITY_EN
    assign parity_ok = ~(^rx);
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync <= '0;
            sdi_sync <= '0;
            ce_sync  <= '0;
            sck_prev <= 1'b0;
            ce_prev  <= 1'b0;
            fill     <= '0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            ce_sync  <= {ce_sync[SYNC_STAGES-2:0], ce};
            sck_prev <= sck_s;
            ce_prev  <= ce_s;
            fill     <= {fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (ce_fall) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed       <= 1'b0;
            count       <= '0;
            rx          <= '0;
            tx          <= '0;
            sdo         <= 1'b0;
            frame       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            // the synchronizer only holds real pin samples once it has refilled after reset
            if (fill[SYNC_STAGES] && !ce_s) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        armed <= 1'b0;
                        count <= '0;
                        rx    <= '0;
                        tx    <= status_in;
                        sdo   <= status_in[STAT_W-1];
                    end
                end
                SHIFT: begin
                    if (sck_rise) begin
                        rx <= {rx[EXPECTED-2:0], sdi_s};
                        if (count != SAT_CNT) begin
                            count <= count + CNT_W'(1);
                        end
                    end
                    if (sck_fall) begin
                        sdo <= tx[STAT_W-2];
                        tx  <= {tx[STAT_W-2:0], 1'b0};
                    end
                end
                DONE: begin
                    sdo <= 1'b0;
                    if (count == EXP_CNT && parity_ok) begin
                        frame       <= payload;
                        frame_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
